// File: rtl/bcd_serial_addsub.sv
// Digit-serial N-digit BCD adder/subtractor (one digit per clock) with per-digit 7-seg drive.
// Optional: define BCD_NEG_RESULT_EN to report a<b subtraction as neg=1 plus magnitude.
module bcd_serial_addsub #(
    parameter int unsigned DIGITS = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  op,
    input  logic [4*DIGITS-1:0]   a,
    input  logic [4*DIGITS-1:0]   b,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   result,
    output logic                  ovf,
    output logic                  invalid,
    output logic                  neg,
    output logic [7*DIGITS-1:0]   seg
);
    localparam int unsigned W  = 4 * DIGITS;
    localparam int unsigned CW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIGITS - 1);

    typedef enum logic [1:0] {StIdle, StRun, StFix, StDone} state_t;

    state_t              state_q, state_d;
    logic [W-1:0]        a_q, a_d, b_q, b_d, sum_q, sum_d;
    logic                op_q, op_d, carry_q, carry_d, inv_q, inv_d;
    logic [CW-1:0]       idx_q, idx_d;
    logic [W-1:0]        result_q, result_d;
    logic [7*DIGITS-1:0] seg_q, seg_d;
    logic                ovf_q, ovf_d, invalid_q, invalid_d, done_q, done_d;
`ifdef BCD_NEG_RESULT_EN
    logic                fix_q, fix_d, neg_q, neg_d;
`endif

    logic [4:0]   dsum, fsum;
    logic         bad, fin_ovf, fin_blank, fin_neg;
    logic [W-1:0] fin_res;

    // Returns {carry_out, digit}; operands are single BCD digits, sum never exceeds 19.
    function automatic logic [4:0] bcd_digit(input logic [3:0] x, input logic [3:0] y,
                                             input logic cin);
        logic [4:0] s;
        s = {1'b0, x} + {1'b0, y} + {4'b0, cin};
        if (s > 5'd9) return {1'b1, 4'(s - 5'd10)};
        return {1'b0, s[3:0]};
    endfunction

    function automatic logic [6:0] seg7(input logic [3:0] d);
        case (d)
            4'd0:    seg7 = 7'b0000001;
            4'd1:    seg7 = 7'b1001111;
            4'd2:    seg7 = 7'b0010010;
            4'd3:    seg7 = 7'b0000110;
            4'd4:    seg7 = 7'b1001100;
            4'd5:    seg7 = 7'b0100100;
            4'd6:    seg7 = 7'b0100000;
            4'd7:    seg7 = 7'b0001111;
            4'd8:    seg7 = 7'b0000000;
            4'd9:    seg7 = 7'b0001100;
            default: seg7 = 7'b1111111;
        endcase
    endfunction

    always_comb begin
        dsum = bcd_digit(a_q[3:0], op_q ? 4'd9 - b_q[3:0] : b_q[3:0], carry_q);
        fsum = bcd_digit(4'd9 - sum_q[3:0], 4'd0, carry_q);
        bad  = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            bad = bad | (a_q[4*i +: 4] > 4'd9) | (b_q[4*i +: 4] > 4'd9);
        end

        fin_res   = sum_q;
        fin_ovf   = 1'b0;
        fin_blank = 1'b0;
        fin_neg   = 1'b0;
        if (inv_q) begin
            fin_res   = '0;
            fin_blank = 1'b1;
`ifdef BCD_NEG_RESULT_EN
        end else if (fix_q) begin
            fin_neg = 1'b1;
`endif
        end else if (op_q ? !carry_q : carry_q) begin
            fin_res   = '0;
            fin_ovf   = 1'b1;
            fin_blank = 1'b1;
        end
    end

    always_comb begin
        state_d   = state_q;
        a_d       = a_q;
        b_d       = b_q;
        op_d      = op_q;
        carry_d   = carry_q;
        idx_d     = idx_q;
        sum_d     = sum_q;
        inv_d     = inv_q;
        result_d  = result_q;
        seg_d     = seg_q;
        ovf_d     = ovf_q;
        invalid_d = invalid_q;
        done_d    = 1'b0;
`ifdef BCD_NEG_RESULT_EN
        fix_d     = fix_q;
        neg_d     = neg_q;
`endif
        case (state_q)
            StIdle: begin
                if (start) begin
                    a_d     = a;
                    b_d     = b;
                    op_d    = op;
                    carry_d = op;
                    idx_d   = '0;
                    inv_d   = 1'b0;
`ifdef BCD_NEG_RESULT_EN
                    fix_d   = 1'b0;
`endif
                    state_d = StRun;
                end
            end
            StRun: begin
                if (idx_q == '0 && bad) begin
                    inv_d   = 1'b1;
                    state_d = StDone;
                end else begin
                    // Result digits shift in from the top so digit 0 lands at [3:0].
                    carry_d = dsum[4];
                    sum_d   = W'({dsum[3:0], sum_q} >> 4);
                    a_d     = a_q >> 4;
                    b_d     = b_q >> 4;
                    idx_d   = idx_q + 1'b1;
                    if (idx_q == LAST) begin
                        idx_d   = '0;
                        state_d = StDone;
`ifdef BCD_NEG_RESULT_EN
                        // No carry on subtract: raw difference is the ten's complement.
                        if (op_q && !dsum[4]) begin
                            fix_d   = 1'b1;
                            carry_d = 1'b1;
                            state_d = StFix;
                        end
`endif
                    end
                end
            end
`ifdef BCD_NEG_RESULT_EN
            StFix: begin
                carry_d = fsum[4];
                sum_d   = W'({fsum[3:0], sum_q} >> 4);
                idx_d   = idx_q + 1'b1;
                if (idx_q == LAST) begin
                    idx_d   = '0;
                    state_d = StDone;
                end
            end
`endif
            StDone: begin
                result_d  = fin_res;
                ovf_d     = fin_ovf;
                invalid_d = inv_q;
                done_d    = 1'b1;
`ifdef BCD_NEG_RESULT_EN
                neg_d     = fin_neg;
`endif
                for (int i = 0; i < DIGITS; i++) begin
                    seg_d[7*i +: 7] = fin_blank ? 7'b1111111 : seg7(fin_res[4*i +: 4]);
                end
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            a_q       <= '0;
            b_q       <= '0;
            op_q      <= 1'b0;
            carry_q   <= 1'b0;
            idx_q     <= '0;
            sum_q     <= '0;
            inv_q     <= 1'b0;
            result_q  <= '0;
            seg_q     <= '1;
            ovf_q     <= 1'b0;
            invalid_q <= 1'b0;
            done_q    <= 1'b0;
`ifdef BCD_NEG_RESULT_EN
            fix_q     <= 1'b0;
            neg_q     <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            a_q       <= a_d;
            b_q       <= b_d;
            op_q      <= op_d;
            carry_q   <= carry_d;
            idx_q     <= idx_d;
            sum_q     <= sum_d;
            inv_q     <= inv_d;
            result_q  <= result_d;
            seg_q     <= seg_d;
            ovf_q     <= ovf_d;
            invalid_q <= invalid_d;
            done_q    <= done_d;
`ifdef BCD_NEG_RESULT_EN
            fix_q     <= fix_d;
            neg_q     <= neg_d;
`endif
        end
    end

    assign busy    = (state_q != StIdle);
    assign done    = done_q;
    assign result  = result_q;
    assign ovf     = ovf_q;
    assign invalid = invalid_q;
    assign seg     = seg_q;
`ifdef BCD_NEG_RESULT_EN
    assign neg     = neg_q;
`else
    assign neg     = 1'b0;
`endif

endmodule
